alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU,
// with a single-entry registered response buffer and per-requester counters.
package alu_arbiter_pkg;
    localparam logic [2:0] ALU_NOP         = 3'd0;
    localparam logic [2:0] ALU_ARITH       = 3'd1;
    localparam logic [2:0] ALU_ARITH_IMM   = 3'd2;
    localparam logic [2:0] ALU_BRANCH_COND = 3'd3;
    localparam logic [3:0] FUNC_ADD        = 4'd0;
    localparam logic [3:0] FUNC_SUB        = 4'd1;
    localparam logic [1:0] SIGN_POS        = 2'b00;
    localparam logic [1:0] SIGN_ZERO       = 2'b01;
    localparam logic [1:0] SIGN_NEG        = 2'b10;
endpackage

module alu_arbiter #(
    parameter int LEN   = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*LEN+6:0]     req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*LEN+6:0]     req1_op,
    output logic [LEN-1:0]       alu_rs1,
    output logic [LEN-1:0]       alu_rs2,
    output logic [LEN-1:0]       alu_imm,
    output logic [LEN-1:0]       alu_pc,
    output logic [2:0]           alu_signal,
    output logic [3:0]           alu_func_code,
    input  logic [LEN-1:0]       alu_result,
    input  logic [1:0]           alu_sign_bits,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [LEN-1:0]       resp_result,
    output logic [1:0]           resp_sign_bits,
    output logic                 resp_id,
    output logic [CNT_W-1:0]     issue_cnt0,
    output logic [CNT_W-1:0]     issue_cnt1
);
    import alu_arbiter_pkg::*;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [LEN-1:0]   result_q, result_d;
    logic [1:0]       sign_q, sign_d;
    logic             id_q, id_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             can_issue;
    logic             grant;
    logic             winner;
    logic [4*LEN+6:0] sel_op;

    // rst_n gates issue so no ready is shown while reset is held
    always_comb begin
        can_issue = rst_n && ((state_q == EMPTY) || resp_ready);
        grant     = can_issue && (req0_valid || req1_valid);
        winner    = (req0_valid && req1_valid) ? prio_q : req1_valid;
    end

    assign req0_ready = grant && !winner;
    assign req1_ready = grant && winner;
    assign sel_op     = winner ? req1_op : req0_op;

    always_comb begin
        alu_rs1       = '0;
        alu_rs2       = '0;
        alu_imm       = '0;
        alu_pc        = '0;
        alu_signal    = ALU_NOP;
        alu_func_code = '0;
        if (grant) begin
            alu_rs1       = sel_op[4*LEN+6 -: LEN];
            alu_rs2       = sel_op[3*LEN+6 -: LEN];
            alu_imm       = sel_op[2*LEN+6 -: LEN];
            alu_pc        = sel_op[LEN+6 -: LEN];
            alu_signal    = sel_op[6:4];
            alu_func_code = sel_op[3:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        sign_d   = sign_q;
        id_d     = id_q;
        prio_d   = prio_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        unique case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (resp_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (grant) begin
            result_d = alu_result;
            sign_d   = alu_sign_bits;
            id_d     = winner;
            prio_d   = ~winner;
        end
        if (req0_ready && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (req1_ready && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            result_q <= '0;
            sign_q   <= '0;
            id_q     <= 1'b0;
            prio_q   <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            id_q     <= id_d;
            prio_q   <= prio_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign resp_valid     = (state_q == FULL);
    assign resp_result    = result_q;
    assign resp_sign_bits = sign_q;
    assign resp_id        = id_q;
    assign issue_cnt0     = cnt0_q;
    assign issue_cnt1     = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, grant/buffer model
// and a scoreboard queue of expected responses.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int LEN   = 32;
    localparam int CNT_W = 4;
    localparam int OP_W  = 4*LEN+7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [OP_W-1:0]  req0_op = '0, req1_op = '0;
    logic [LEN-1:0]   alu_rs1, alu_rs2, alu_imm, alu_pc;
    logic [2:0]       alu_signal;
    logic [3:0]       alu_func_code;
    logic [LEN-1:0]   alu_result;
    logic [1:0]       alu_sign_bits;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [LEN-1:0]   resp_result;
    logic [1:0]       resp_sign_bits;
    logic             resp_id;
    logic [CNT_W-1:0] issue_cnt0, issue_cnt1;

    int vectors = 0;
    int miscompares = 0;

    bit               full_m = 1'b0;
    bit               prio_m = 1'b0;
    logic [CNT_W-1:0] c0_m = '0, c1_m = '0;
    logic [LEN+2:0]   last_m = '0;
    logic [LEN+2:0]   sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_signal(alu_signal),
        .alu_func_code(alu_func_code),
        .alu_result(alu_result), .alu_sign_bits(alu_sign_bits),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_sign_bits(resp_sign_bits),
        .resp_id(resp_id),
        .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
    );

    function automatic logic [LEN+1:0] alu_ref(
        input logic [LEN-1:0] a, input logic [LEN-1:0] b,
        input logic [LEN-1:0] imm, input logic [2:0] sig,
        input logic [3:0] fc);
        logic [LEN-1:0] r;
        logic [1:0]     s;
        case (sig)
            ALU_ARITH:       r = (fc == FUNC_SUB) ? a - b : a + b;
            ALU_ARITH_IMM:   r = a + imm;
            ALU_BRANCH_COND: r = a - b;
            default:         r = '0;
        endcase
        if (r == '0)        s = SIGN_ZERO;
        else if (r[LEN-1])  s = SIGN_NEG;
        else                s = SIGN_POS;
        return {s, r};
    endfunction

    always_comb
        {alu_sign_bits, alu_result} = alu_ref(alu_rs1, alu_rs2, alu_imm,
                                              alu_signal, alu_func_code);

    function automatic logic [OP_W-1:0] mk_op(
        input logic [LEN-1:0] rs1, input logic [LEN-1:0] rs2,
        input logic [LEN-1:0] imm, input logic [LEN-1:0] pc,
        input logic [2:0] sig, input logic [3:0] fc);
        return {rs1, rs2, imm, pc, sig, fc};
    endfunction

    function automatic logic [LEN+2:0] exp_of(input logic [OP_W-1:0] op,
                                              input logic id);
        return {alu_ref(op[4*LEN+6 -: LEN], op[3*LEN+6 -: LEN],
                        op[2*LEN+6 -: LEN], op[6:4], op[3:0]), id};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check grant at negedge, then response/counters after the edge
    task automatic step();
        logic g, win;
        @(negedge clk);
        g   = (!full_m || resp_ready) && (req0_valid || req1_valid);
        win = (req0_valid && req1_valid) ? prio_m : req1_valid;
        check("req0_ready", req0_ready, g && !win);
        check("req1_ready", req1_ready, g && win);
        if (g) begin
            sb.push_back(exp_of(win ? req1_op : req0_op, win));
            full_m = 1'b1;
            prio_m = !win;
            if (!win && c0_m != '1) c0_m = c0_m + 1'b1;
            if (win && c1_m != '1)  c1_m = c1_m + 1'b1;
        end else if (full_m && resp_ready) begin
            full_m = 1'b0;
        end
        @(posedge clk);
        #1;
        check("resp_valid", resp_valid, full_m);
        if (g && sb.size() > 0) last_m = sb.pop_front();
        check("resp_fields", {resp_sign_bits, resp_result, resp_id}, last_m);
        check("issue_cnt0", issue_cnt0, c0_m);
        check("issue_cnt1", issue_cnt1, c1_m);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_fields", {resp_sign_bits, resp_result, resp_id}, 0);
        check("rst_cnt0", issue_cnt0, 0);
        check("rst_cnt1", issue_cnt1, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_alu_nop", alu_signal, ALU_NOP);
        full_m = 1'b0;
        prio_m = 1'b0;
        c0_m   = '0;
        c1_m   = '0;
        last_m = '0;
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_held_ready", {req0_ready, req1_ready}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        req0_op    = mk_op(32'd5, 32'd0, 32'd3, 32'h100, ALU_ARITH_IMM, FUNC_ADD);
        req1_op    = mk_op(32'd7, 32'd9, 32'd0, 32'h200, ALU_ARITH, FUNC_ADD);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        #2;
        apply_reset();

        // Alternating grants with both requesters valid
        step();
        check("a_res_8", resp_result, 8);
        check("a_id_0", resp_id, 0);
        step();
        check("a_res_16", resp_result, 16);
        check("a_id_1", resp_id, 1);
        step();

        // Reset mid-stream while a result is buffered; prio was pointing at req1
        check("d_pre_valid", resp_valid, 1);
        apply_reset();
        step();
        check("d_prio0_id", resp_id, 0);

        // Only req1 valid for four cycles
        apply_reset();
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("b_cnt1_4", issue_cnt1, 4);
        check("b_cnt0_0", issue_cnt0, 0);

        // Back-pressure with both valid, then same-cycle drain and refill
        req0_valid = 1'b1;
        step();
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req1_op = mk_op(32'd20 + i, 32'd30, 32'd0, 32'h0, ALU_ARITH, FUNC_ADD);
            step();
        end
        resp_ready = 1'b1;
        step();
        check("c_refill_id", resp_id, 1);
        check("c_refill_res", resp_result, 52);

        // Drain with no requester, then a signed subtract
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        req1_op    = mk_op(32'd3, 32'd10, 32'd0, 32'h0, ALU_ARITH, FUNC_SUB);
        req1_valid = 1'b1;
        step();
        check("sub_sign_neg", resp_sign_bits, SIGN_NEG);
        req1_valid = 1'b0;

        // Branch compare of equal operands
        req0_op    = mk_op(32'd4, 32'd4, 32'd0, 32'h40, ALU_BRANCH_COND, FUNC_SUB);
        req0_valid = 1'b1;
        step();
        check("br_res_0", resp_result, 0);
        check("br_sign_zero", resp_sign_bits, SIGN_ZERO);

        // Counter saturation for req0
        apply_reset();
        req0_op = mk_op(32'd1, 32'd0, 32'd1, 32'h0, ALU_ARITH_IMM, FUNC_ADD);
        for (int i = 0; i < 17; i++) step();
        check("sat_cnt0_15", issue_cnt0, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
